// File: rtl/file_writer_arbiter.sv
// Round-robin arbiter sharing one file-writer port among NUM_REQ producers.
// Each grant produces a one-cycle enable pulse, followed by a mandatory low gap.
module file_writer_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_enable,
    output logic                          wr_done,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [CNT_WIDTH-1:0]          wr_count,
    output logic                          busy,
    output logic                          closed,
    output logic                          err_proto
);

    localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned N     = NUM_REQ;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        GAP,
        CLOSED
    } state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] retired;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_found;
    logic               grant_final;
    logic               final_flag;
    logic               take;

    assign eligible = req_valid & ~retired;

    // Search upward from ptr+1 with wrap; the first eligible index wins.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[PTR_W-1:0];
            end
        end
    end

    assign grant_oh    = NUM_REQ'(1) << grant_idx;
    assign grant_final = req_last[grant_idx] && (&(retired | grant_oh));
    assign take        = (state == IDLE) && grant_found;

    always_comb begin
        state_next = state;
        req_ready  = '0;
        wr_enable  = 1'b0;
        wr_done    = 1'b0;
        busy       = 1'b0;
        closed     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready  = grant_oh;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_enable  = 1'b1;
                busy       = 1'b1;
                state_next = GAP;
            end
            GAP: begin
                busy       = 1'b1;
                wr_done    = final_flag;
                state_next = final_flag ? CLOSED : IDLE;
            end
            CLOSED: begin
                wr_done = 1'b1;
                closed  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= PTR_W'(NUM_REQ - 1);
            retired    <= '0;
            final_flag <= 1'b0;
            wr_data    <= '0;
            wr_count   <= '0;
            err_proto  <= 1'b0;
        end else begin
            state <= state_next;
            if (take) begin
                wr_data    <= req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                ptr        <= grant_idx;
                final_flag <= grant_final;
                if (req_last[grant_idx]) begin
                    retired <= retired | grant_oh;
                end
            end
            if (state == WRITE && wr_count != '1) begin
                wr_count <= wr_count + 1'b1;
            end
            // Retired requesters are never eligible, so their words are dropped here.
            if ((|(req_valid & retired)) || (state == CLOSED && |req_valid)) begin
                err_proto <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_file_writer_arbiter.sv
// Bench for file_writer_arbiter: randomized producers checked every cycle against
// a timing model built on grant times, round-robin order and retirement sets.
module tb_file_writer_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              wr_enable;
    logic              wr_done;
    logic [DW-1:0]     wr_data;
    logic [CW-1:0]     wr_count;
    logic              busy;
    logic              closed;
    logic              err_proto;

    file_writer_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wr_enable (wr_enable),
        .wr_done   (wr_done),
        .wr_data   (wr_data),
        .wr_count  (wr_count),
        .busy      (busy),
        .closed    (closed),
        .err_proto (err_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         last;
        logic [7:0] data;
    } word_t;

    word_t      q[NR][$];
    bit         hold[NR];
    int         order[$];
    logic [7:0] dlist[$];

    int         n_cmp;
    int         n_fail;

    // Reference model: timing follows from the cycle of the most recent grant.
    int         cyc;
    int         lg;
    int         m_ptr;
    bit [NR-1:0] m_ret;
    bit         m_final;
    logic [7:0] m_data;
    int         m_count;
    bit         m_err;
    int         wseen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lg      = cyc - 100;
        m_ptr   = NR - 1;
        m_ret   = '0;
        m_final = 1'b0;
        m_data  = '0;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic clear_producers();
        for (int i = 0; i < NR; i++) begin
            q[i].delete();
            hold[i] = 1'b0;
        end
        order.delete();
        dlist.delete();
        wseen = 0;
    endtask

    task automatic push(input int i, input logic [7:0] d, input bit l);
        word_t w;
        w.data = d;
        w.last = l;
        q[i].push_back(w);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_producers();
        model_reset();
    endtask

    task automatic build_random(input int nmin, input int nmax);
        clear_producers();
        for (int i = 0; i < NR; i++) begin
            int n;
            n = $urandom_range(nmax, nmin);
            for (int k = 0; k < n; k++) push(i, 8'($urandom), k == n - 1);
        end
    endtask

    task automatic build_rr();
        clear_producers();
        for (int i = 0; i < NR; i++) begin
            push(i, 8'($urandom), 1'b0);
            push(i, 8'($urandom), 1'b1);
        end
    endtask

    task automatic cycle(input int prob, input bit inject, input bit rst_now);
        int          g;
        int          idx;
        bit          idle;
        bit          bad;
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] acc;
        @(negedge clk);
        reset = rst_now;
        for (int i = 0; i < NR; i++) begin
            if (!hold[i] && q[i].size() > 0 && int'($urandom_range(99)) < prob) hold[i] = 1'b1;
            bad = inject && !rst_now && q[i].size() == 0 && $urandom_range(99) < 4;
            req_valid[i] = hold[i] | bad;
            if (hold[i]) begin
                req_data[i*DW +: DW] = q[i][0].data;
                req_last[i]          = q[i][0].last;
            end else begin
                req_data[i*DW +: DW] = 8'($urandom);
                req_last[i]          = 1'($urandom);
            end
        end
        #1;
        idle = (cyc >= lg + 3) && !m_final;
        g = -1;
        if (idle) begin
            for (int k = 1; k <= NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && req_valid[idx] && !m_ret[idx]) g = idx;
            end
        end
        exp_ready = (g >= 0) ? (NR'(1) << g) : '0;
        chk("ready",  32'(req_ready), 32'(exp_ready));
        chk("enable", 32'(wr_enable), 32'(cyc == lg + 1));
        chk("done",   32'(wr_done),   32'(m_final && cyc >= lg + 2));
        chk("closed", 32'(closed),    32'(m_final && cyc >= lg + 3));
        chk("busy",   32'(busy),      32'(cyc == lg + 1 || cyc == lg + 2));
        chk("data",   32'(wr_data),   32'(m_data));
        chk("count",  32'(wr_count),  32'(m_count));
        chk("err",    32'(err_proto), 32'(m_err));
        acc = req_ready & req_valid;
        for (int i = 0; i < NR; i++) if (acc[i]) order.push_back(i);
        if (wr_enable === 1'b1) dlist.push_back(wr_data);
        if (cyc == lg + 1) wseen++;
        if (rst_now) begin
            clear_producers();
            model_reset();
        end else begin
            if ((|(req_valid & m_ret)) || (m_final && cyc >= lg + 3 && |req_valid)) m_err = 1'b1;
            if (cyc == lg + 1 && m_count < CMAX) m_count++;
            if (g >= 0) begin
                m_data  = req_data[g*DW +: DW];
                m_ptr   = g;
                m_final = req_last[g] && ((m_ret | (NR'(1) << g)) == {NR{1'b1}});
                if (req_last[g]) m_ret[g] = 1'b1;
                lg = cyc;
                void'(q[g].pop_front());
                hold[g] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic run(input int prob, input bit inject, input int reset_k, input int budget);
        bit rst_now;
        for (int t = 0; t < budget; t++) begin
            rst_now = (reset_k > 0) && (cyc == lg + 1) && (wseen + 1 == reset_k);
            cycle(prob, inject, rst_now);
            if (rst_now) break;
            if (m_final && cyc >= lg + 6) break;
        end
        if (reset_k == 0) chk("closed_by_budget", 32'(closed), 32'd1);
    endtask

    int exp_s1[6];
    int exp_rr[8];

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        n_cmp     = 0;
        n_fail    = 0;
        cyc       = 0;
        exp_s1 = '{8'h11, 8'h44, 8'h55, 8'h66, 8'h22, 8'h33};
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};

        apply_reset();
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        push(1, 8'h44, 1'b1);
        push(2, 8'h55, 1'b1);
        push(3, 8'h66, 1'b1);
        run(100, 1'b0, 0, 200);
        for (int k = 0; k < 6; k++)
            chk($sformatf("s1_data%0d", k), (dlist.size() > k) ? 32'(dlist[k]) : 32'hFFFF_FFFF, 32'(exp_s1[k]));
        chk("s1_count", 32'(wr_count), 32'd6);

        apply_reset();
        build_rr();
        run(100, 1'b0, 0, 200);
        for (int k = 0; k < 8; k++)
            chk($sformatf("rr_order%0d", k), (order.size() > k) ? 32'(order[k]) : 32'hFFFF_FFFF, 32'(exp_rr[k]));
        chk("rr_count", 32'(wr_count), 32'd8);

        apply_reset();
        build_random(1, 4);
        run(70, 1'b0, 3, 400);
        build_rr();
        run(100, 1'b0, 0, 200);
        for (int k = 0; k < 8; k++)
            chk($sformatf("post_reset_order%0d", k), (order.size() > k) ? 32'(order[k]) : 32'hFFFF_FFFF, 32'(exp_rr[k]));

        apply_reset();
        build_random(5, 8);
        run(60, 1'b1, 0, 1000);
        chk("sat_count", 32'(wr_count), 32'(CMAX));

        for (int s = 0; s < 3; s++) begin
            apply_reset();
            build_random(1, 6);
            run(int'($urandom_range(100, 30)), 1'b1, 0, 800);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
